// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and the
// oversampling rate common to the TX and RX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter: the grant is combinational, the pointer
// remembers the last requester served once a grant is taken.
module uart_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_gnt_valid,
  output logic       o_gnt_idx
);

  logic ptr;
  logic served;

  // Until anyone has been served, a tie goes to requester 0.
  always_comb begin
    o_gnt_valid = |i_req;
    if (i_req == 2'b11) begin
      o_gnt_idx = served ? ~ptr : 1'b0;
    end else begin
      o_gnt_idx = i_req[1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr    <= 1'b0;
      served <= 1'b0;
    end else if (i_take && o_gnt_valid) begin
      ptr    <= o_gnt_idx;
      served <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates two byte sources onto one serial line,
// gates the baud generator and serializes each frame on 16x baud ticks.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_baud_tick,
  output logic                 o_baud_en,
  input  logic                 i_valid0,
  input  logic [DATA_BITS-1:0] i_data0,
  output logic                 o_ready0,
  input  logic                 i_valid1,
  input  logic [DATA_BITS-1:0] i_data1,
  output logic                 o_ready1,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t          state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic                 gnt_valid;
  logic                 gnt_idx;
  logic [DATA_BITS-1:0] gnt_data;

  uart_rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       ({i_valid1, i_valid0}),
    .i_take      (state == ST_IDLE),
    .o_gnt_valid (gnt_valid),
    .o_gnt_idx   (gnt_idx)
  );

  assign gnt_data = gnt_idx ? i_data1 : i_data0;

  // Parity is fixed at grant time so the shifting register cannot disturb it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      o_tx       <= 1'b1;
      o_baud_en  <= 1'b0;
      o_ready0   <= 1'b0;
      o_ready1   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_ready0 <= 1'b0;
      o_ready1 <= 1'b0;
      o_done   <= 1'b0;
      if (state == ST_IDLE) begin
        if (gnt_valid) begin
          state      <= ST_START;
          shift_reg  <= gnt_data;
          parity_bit <= (^gnt_data) ^ (PARITY == PAR_ODD);
          o_ready0   <= ~gnt_idx;
          o_ready1   <= gnt_idx;
          o_tx       <= 1'b0;
          o_baud_en  <= 1'b1;
          o_busy     <= 1'b1;
          tick_cnt   <= '0;
          bit_idx    <= '0;
        end
      end else if (i_baud_tick) begin
        if (tick_cnt != TICK_LAST) begin
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          tick_cnt <= '0;
          case (state)
            ST_START: begin
              state <= ST_DATA;
              o_tx  <= shift_reg[0];
            end
            ST_DATA: begin
              shift_reg <= shift_reg >> 1;
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
                if (PARITY != PAR_NONE) begin
                  state <= ST_PARITY;
                  o_tx  <= parity_bit;
                end else begin
                  state <= ST_STOP;
                  o_tx  <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                o_tx    <= shift_reg[1];
              end
            end
            ST_PARITY: begin
              state <= ST_STOP;
              o_tx  <= 1'b1;
            end
            ST_STOP: begin
              if (bit_idx == STOP_LAST) begin
                state     <= ST_IDLE;
                bit_idx   <= '0;
                o_tx      <= 1'b1;
                o_done    <= 1'b1;
                o_busy    <= 1'b0;
                o_baud_en <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: four instances (default, even parity,
// odd parity, even parity with two stop bits) share one stimulus stream.
module tb_uart_tx_sched;

  logic       i_clk;
  logic       i_reset;
  logic       i_baud_tick;
  logic       i_valid0;
  logic       i_valid1;
  logic [7:0] i_data0;
  logic [7:0] i_data1;

  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] en_v;
  logic [3:0] r0_v;
  logic [3:0] r1_v;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic tick_prev;

  logic [15:0] cap [4];
  int          done_tick [4];
  int          done_cnt [4];
  int          en_cnt [4];
  int          rdy0_cnt;
  int          rdy1_cnt;
  int          first_gnt;
  logic        first_busy;
  logic        first_tx;
  int          tcount;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_sched #(
      .DATA_BITS  (8),
      .PARITY     ((g == 0) ? 0 : (g == 2) ? 1 : 2),
      .STOP_BITS  ((g == 3) ? 2 : 1),
      .OVERSAMPLE (16)
    ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_baud_tick (i_baud_tick),
      .o_baud_en   (en_v[g]),
      .i_valid0    (i_valid0),
      .i_data0     (i_data0),
      .o_ready0    (r0_v[g]),
      .i_valid1    (i_valid1),
      .i_data1     (i_data1),
      .o_ready1    (r1_v[g]),
      .o_tx        (tx_v[g]),
      .o_busy      (busy_v[g]),
      .o_done      (done_v[g])
    );
  end

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the falling edge, note the tick the last rising edge
  // consumed, and schedule a tick every fourth cycle.
  task automatic apply_stimulus();
    @(negedge i_clk);
    tick_prev   = i_baud_tick;
    cyc++;
    i_baud_tick = (cyc % 4 == 0);
  endtask

  task automatic align();
    do apply_stimulus(); while (cyc % 4 != 0);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    apply_stimulus();
    i_reset = 1'b0;
    apply_stimulus();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_v != 4'b0000 && n < 2000) begin
      apply_stimulus();
      n++;
    end
    check_output("wait_idle", {28'd0, busy_v}, 32'd0);
  endtask

  // Follows one frame from its grant edge until nend ticks have been
  // consumed, sampling every instance in the middle of each bit slot.
  task automatic capture(input int nend, input bit keep, input int pulse1_at);
    int k = 0;
    tcount   = 0;
    rdy0_cnt = 0;
    rdy1_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cap[i]       = '0;
      done_tick[i] = -1;
      done_cnt[i]  = 0;
      en_cnt[i]    = 0;
    end
    while (tcount < nend && k < nend * 4 + 40) begin
      apply_stimulus();
      k++;
      if (k > 1 && tick_prev) tcount++;
      if (k == 1) begin
        first_busy = busy_v[0];
        first_tx   = tx_v[0];
        first_gnt  = r0_v[0] ? 0 : (r1_v[0] ? 1 : -1);
      end
      for (int i = 0; i < 4; i++) begin
        if (k > 1 && tick_prev && (tcount % 16 == 8)) cap[i][tcount / 16] = tx_v[i];
        if (en_v[i]) en_cnt[i]++;
        if (done_v[i]) begin
          done_cnt[i]++;
          done_tick[i] = tcount;
        end
      end
      if (r0_v[0]) rdy0_cnt++;
      if (r1_v[0]) rdy1_cnt++;
      if (!keep) begin
        if (r0_v[0]) i_valid0 = 1'b0;
        if (r1_v[0]) i_valid1 = 1'b0;
      end
      if (pulse1_at > 0) i_valid1 = (k > 1 && tick_prev && tcount == pulse1_at);
    end
    check_output("frame_ticks", tcount, nend);
  endtask

  initial begin
    int n;
    int tc;
    i_reset     = 1'b0;
    i_baud_tick = 1'b0;
    i_valid0    = 1'b0;
    i_valid1    = 1'b0;
    i_data0     = 8'h00;
    i_data1     = 8'h00;

    #2 i_reset = 1'b1;
    #1;
    check_output("rst_tx", tx_v[0], 1);
    check_output("rst_busy", busy_v[0], 0);
    check_output("rst_baud_en", en_v[0], 0);
    check_output("rst_ready", {r1_v[0], r0_v[0]}, 0);
    check_output("rst_done", done_v[0], 0);
    apply_stimulus();
    apply_stimulus();
    i_reset = 1'b0;

    // Ticks while idle must leave the line high and the generator disabled.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus();
      if (tx_v[0] !== 1'b1 || en_v[0] !== 1'b0 || busy_v[0] !== 1'b0) n++;
    end
    check_output("idle_ticks_ignored", n, 0);

    // Single frame of 8'hA5 on requester 0, tick-aligned.
    align();
    i_valid0 = 1'b1;
    i_data0  = 8'hA5;
    capture(160, 1'b0, 0);
    check_output("a5_first_busy", first_busy, 1);
    check_output("a5_first_tx", first_tx, 0);
    check_output("a5_grant", first_gnt, 0);
    check_output("a5_ready_pulses", rdy0_cnt + rdy1_cnt, 1);
    check_output("a5_line", cap[0][9:0], 10'h34A);
    check_output("a5_baud_en_cycles", en_cnt[0], 640);
    check_output("a5_done_count", done_cnt[0], 1);
    check_output("a5_done_tick", done_tick[0], 160);
    wait_idle();

    // Both requesters held valid: alternate grants, back-to-back frames.
    pulse_reset();
    i_data0  = 8'h11;
    i_data1  = 8'h22;
    i_valid0 = 1'b1;
    i_valid1 = 1'b1;
    for (int f = 0; f < 4; f++) begin
      capture(160, 1'b1, 0);
      check_output("rr_grant", first_gnt, f % 2);
      check_output("rr_byte", cap[0][8:1], (f % 2) ? 8'h22 : 8'h11);
      check_output("rr_ready_pulses", rdy0_cnt + rdy1_cnt, 1);
      check_output("rr_start_after_done", {first_busy, first_tx}, 2'b10);
      check_output("rr_done_count", done_cnt[0], 1);
    end
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    wait_idle();

    // Byte 8'h07 on all parity/stop configurations.
    align();
    i_valid0 = 1'b1;
    i_data0  = 8'h07;
    capture(192, 1'b0, 0);
    check_output("p_none_line", cap[0][9:0], 10'h20E);
    check_output("p_even_line", cap[1][10:0], 11'h60E);
    check_output("p_odd_line", cap[2][10:0], 11'h40E);
    check_output("stop2_line", cap[3][11:0], 12'hE0E);
    check_output("p_none_done_tick", done_tick[0], 160);
    check_output("p_even_done_tick", done_tick[1], 176);
    check_output("p_odd_done_tick", done_tick[2], 176);
    check_output("stop2_done_tick", done_tick[3], 192);
    check_output("stop2_done_count", done_cnt[3], 1);
    wait_idle();

    // A one-cycle request from requester 1 mid-frame is withdrawn: no grant.
    align();
    i_valid0 = 1'b1;
    i_data0  = 8'hA5;
    capture(160, 1'b0, 40);
    check_output("pulse1_no_ready", rdy1_cnt, 0);
    check_output("pulse1_line", cap[0][9:0], 10'h34A);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus();
      if (busy_v[0] !== 1'b0 || r1_v[0] !== 1'b0) n++;
    end
    check_output("pulse1_no_late_grant", n, 0);
    wait_idle();

    // Reset in the middle of data bit 3 aborts the frame immediately.
    align();
    i_valid0 = 1'b1;
    i_data0  = 8'hA5;
    apply_stimulus();
    i_valid0 = 1'b0;
    tc = 0;
    n  = 0;
    while (tc < 72 && n < 400) begin
      apply_stimulus();
      n++;
      if (tick_prev) tc++;
    end
    check_output("mid_reach_bit3", tc, 72);
    check_output("mid_bit3_level", {busy_v[0], tx_v[0]}, 2'b10);
    i_reset = 1'b1;
    #1;
    check_output("mid_rst_tx", tx_v[0], 1);
    check_output("mid_rst_busy", busy_v[0], 0);
    check_output("mid_rst_baud_en", en_v[0], 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus();
      if (done_v[0] !== 1'b0) n++;
    end
    i_reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus();
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) n++;
    end
    check_output("mid_rst_no_done", n, 0);
    align();
    i_valid0 = 1'b1;
    i_data0  = 8'hA5;
    capture(160, 1'b0, 0);
    check_output("post_rst_line", cap[0][9:0], 10'h34A);
    check_output("post_rst_done_tick", done_tick[0], 160);
    check_output("post_rst_baud_en_cycles", en_cnt[0], 640);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
